// File: rtl/visitor_dir_detect.sv
// visitor_dir_detect: debounced two-beam doorway direction decoder emitting inc/dec pulses
// Optional build macro VISITOR_SKIP_TOLERANT_EN lets EN1/EX1 and EN3/EX3 jump across same-cycle beam swaps.
module visitor_dir_detect #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic inc,
  output logic dec,
  output logic busy,
  output logic fault
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT_CLEAR} state_t;
`ifdef VISITOR_SKIP_TOLERANT_EN
  localparam state_t EN1_SWAP = EN3;
  localparam state_t EN3_SWAP = EN1;
  localparam state_t EX1_SWAP = EX3;
  localparam state_t EX3_SWAP = EX1;
`else
  localparam state_t EN1_SWAP = WAIT_CLEAR;
  localparam state_t EN3_SWAP = WAIT_CLEAR;
  localparam state_t EX1_SWAP = WAIT_CLEAR;
  localparam state_t EX3_SWAP = WAIT_CLEAR;
`endif
  logic [1:0] w_raw;
  logic [1:0] w_f;
  state_t r_state;
  state_t w_next;
  logic [TW-1:0] r_timer;
  logic w_in_seq;
  assign w_raw = {sensor_a, sensor_b};
  // Index 1 is the outer beam A, index 0 the inner beam B, so w_f reads as {fa,fb}.
  for (genvar i = 0; i < 2; i++) begin : g_db
    logic [1:0] r_sync;
    logic [DW-1:0] r_cnt;
    logic r_lvl;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync <= '0;
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else begin
        r_sync <= {r_sync[0], w_raw[i]};
        if (r_sync[1] == r_lvl) r_cnt <= '0;
        else if (r_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_lvl <= r_sync[1];
          r_cnt <= '0;
        end else r_cnt <= r_cnt + 1'b1;
      end
    end
    assign w_f[i] = r_lvl;
  end
  assign w_in_seq = (r_state != IDLE) && (r_state != WAIT_CLEAR);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       w_next = w_f == 2'b10 ? EN1 : w_f == 2'b01 ? EX1 : w_f == 2'b11 ? WAIT_CLEAR : IDLE;
      EN1:        w_next = w_f == 2'b11 ? EN2 : w_f == 2'b00 ? IDLE : w_f == 2'b01 ? EN1_SWAP : EN1;
      EN2:        w_next = w_f == 2'b01 ? EN3 : w_f == 2'b10 ? EN1 : w_f == 2'b00 ? IDLE : EN2;
      EN3:        w_next = w_f == 2'b00 ? IDLE : w_f == 2'b11 ? EN2 : w_f == 2'b10 ? EN3_SWAP : EN3;
      EX1:        w_next = w_f == 2'b11 ? EX2 : w_f == 2'b00 ? IDLE : w_f == 2'b10 ? EX1_SWAP : EX1;
      EX2:        w_next = w_f == 2'b10 ? EX3 : w_f == 2'b01 ? EX1 : w_f == 2'b00 ? IDLE : EX2;
      EX3:        w_next = w_f == 2'b00 ? IDLE : w_f == 2'b11 ? EX2 : w_f == 2'b01 ? EX3_SWAP : EX3;
      WAIT_CLEAR: w_next = w_f == 2'b00 ? IDLE : WAIT_CLEAR;
      default:    w_next = IDLE;
    endcase
    // A stalled sequence is abandoned regardless of what the beams are doing this cycle.
    if (w_in_seq && r_timer == TW'(TIMEOUT_CYCLES - 1)) w_next = WAIT_CLEAR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_timer <= '0;
      inc <= 1'b0;
      dec <= 1'b0;
      busy <= 1'b0;
      fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_timer <= w_in_seq ? r_timer + 1'b1 : '0;
      inc <= (r_state == EN3) && (w_next == IDLE);
      dec <= (r_state == EX3) && (w_next == IDLE);
      busy <= w_next != IDLE;
      fault <= w_next == WAIT_CLEAR;
    end
  end
endmodule

// File: tb/tb_visitor_dir_detect.sv
// tb_visitor_dir_detect: directed entry/exit/glitch/timeout/reset/skip checks
// Instance dut uses defaults, dut_t uses TIMEOUT_CYCLES=50 for the timeout case.
module tb_visitor_dir_detect;
`ifdef VISITOR_SKIP_TOLERANT_EN
  localparam int SKIP = 1;
`else
  localparam int SKIP = 0;
`endif
  logic clk = 0, rst = 1, sensor_a = 0, sensor_b = 0;
  logic inc0, dec0, busy0, fault0, inc1, dec1, busy1, fault1;
  logic [1:0] m_inc, m_dec, m_busy, m_fault;
  logic [1:0] p_inc = 0, p_dec = 0, p_busy = 0, p_fault = 0;
  int checks = 0, failures = 0, cyc = 0, t0 = 0;
  int wide_n = 0, both_n = 0;
  int inc_n[2], dec_n[2], busy_n[2], fault_n[2], inc_at[2], dec_at[2], busy_up[2], fault_up[2];
  int b_inc[2], b_dec[2], b_busy[2], b_fault[2];
  visitor_dir_detect dut (
    .clk(clk), .rst(rst), .sensor_a(sensor_a), .sensor_b(sensor_b),
    .inc(inc0), .dec(dec0), .busy(busy0), .fault(fault0)
  );
  visitor_dir_detect #(.TIMEOUT_CYCLES(50)) dut_t (
    .clk(clk), .rst(rst), .sensor_a(sensor_a), .sensor_b(sensor_b),
    .inc(inc1), .dec(dec1), .busy(busy1), .fault(fault1)
  );
  assign m_inc = {inc1, inc0};
  assign m_dec = {dec1, dec0};
  assign m_busy = {busy1, busy0};
  assign m_fault = {fault1, fault0};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_inc[i]) begin inc_n[i]++; inc_at[i] = cyc; end
      if (m_dec[i]) begin dec_n[i]++; dec_at[i] = cyc; end
      if (m_busy[i]) busy_n[i]++;
      if (m_fault[i]) fault_n[i]++;
      if (m_busy[i] && !p_busy[i]) busy_up[i] = cyc;
      if (m_fault[i] && !p_fault[i]) fault_up[i] = cyc;
      if ((m_inc[i] && p_inc[i]) || (m_dec[i] && p_dec[i])) wide_n++;
      if (m_inc[i] && m_dec[i]) both_n++;
    end
    p_inc = m_inc;
    p_dec = m_dec;
    p_busy = m_busy;
    p_fault = m_fault;
  end
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic hold(input logic a, input logic b, input int n);
    sensor_a = a;
    sensor_b = b;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic snap();
    b_inc = inc_n;
    b_dec = dec_n;
    b_busy = busy_n;
    b_fault = fault_n;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_outs", {inc0, dec0, busy0, fault0}, 0);
    chk("rst_outs_t", {inc1, dec1, busy1, fault1}, 0);
    snap();
    hold(1, 0, 20);
    chk("en_busy_a", busy0, 1);
    hold(1, 1, 20);
    hold(0, 1, 20);
    t0 = cyc;
    hold(0, 0, 20);
    chk("en_inc", inc_n[0] - b_inc[0], 1);
    chk("en_lat", inc_at[0] - t0, 7);
    chk("en_dec", dec_n[0] - b_dec[0], 0);
    chk("en_busy_end", busy0, 0);
    snap();
    hold(0, 1, 20);
    hold(1, 1, 20);
    hold(1, 0, 20);
    t0 = cyc;
    hold(0, 0, 20);
    chk("ex_dec", dec_n[0] - b_dec[0], 1);
    chk("ex_lat", dec_at[0] - t0, 7);
    chk("ex_inc", inc_n[0] - b_inc[0], 0);
    chk("ex_busy_end", busy0, 0);
    snap();
    hold(1, 0, 3);
    hold(0, 0, 20);
    chk("gl_busy", busy_n[0] - b_busy[0], 0);
    chk("gl_pulse", (inc_n[0] - b_inc[0]) + (dec_n[0] - b_dec[0]), 0);
    snap();
    hold(1, 0, 20);
    hold(0, 0, 20);
    chk("ab_busy_seen", busy_n[0] > b_busy[0], 1);
    chk("ab_busy_end", busy0, 0);
    chk("ab_pulse", (inc_n[0] - b_inc[0]) + (dec_n[0] - b_dec[0]), 0);
    snap();
    t0 = cyc;
    hold(1, 0, 200);
    chk("to_fault", fault1, 1);
    chk("to_fresh", busy_up[1] > t0, 1);
    chk("to_lat", fault_up[1] - busy_up[1], 50);
    chk("to_dflt_nofault", fault0, 0);
    hold(0, 0, 20);
    chk("to_clear", {busy1, fault1}, 0);
    chk("to_pulse", (inc_n[1] - b_inc[1]) + (dec_n[1] - b_dec[1]), 0);
    hold(1, 0, 20);
    hold(1, 1, 20);
    chk("rm_busy", busy0, 1);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("rm_outs", {inc0, dec0, busy0, fault0}, 0);
    chk("rm_outs_t", {inc1, dec1, busy1, fault1}, 0);
    snap();
    hold(0, 1, 20);
    hold(0, 0, 20);
    chk("rm_inc", inc_n[0] - b_inc[0], 0);
    chk("rm_dec", dec_n[0] - b_dec[0], 0);
    chk("rm_busy_end", busy0, 0);
    snap();
    hold(1, 0, 20);
    hold(0, 1, 20);
    hold(0, 0, 20);
    chk("sk_fault", fault_n[0] > b_fault[0], 1 - SKIP);
    chk("sk_inc", inc_n[0] - b_inc[0], SKIP);
    chk("sk_busy_end", busy0, 0);
    chk("pulse_width", wide_n, 0);
    chk("inc_dec_overlap", both_n, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
